// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle for hazard_fwd_unit.
//   slave  : seen by the hazard/forwarding unit (ID/EX/MEM state in, selects and stalls out)
//   master : seen by the pipeline that drives the stage state and consumes the results
// Signals:
//   id_*     operands / kind of the instruction in ID, flush kills it
//   ex_*     destination, write-enable, load flag and mc-issue of the instruction in EX
//   mem_*    destination and write-enable of the instruction in MEM
//   fwa/fwb  registered EX operand selects (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   stall    combinational pipeline hold request
//   mc_busy, mc_wb_req  multi-cycle scoreboard status
//   stall_cnt           saturating stalled-cycle counter
interface hazard_fwd_unit_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 16
);
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_is_mc;
    logic              flush;
    logic [ADDR_W-1:0] ex_rd;
    logic              ex_regwen;
    logic              ex_is_load;
    logic              ex_mc_issue;
    logic [ADDR_W-1:0] mem_rd;
    logic              mem_regwen;
    logic [1:0]        fwa;
    logic [1:0]        fwb;
    logic              stall;
    logic              mc_busy;
    logic              mc_wb_req;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_mc, flush,
        input  ex_rd, ex_regwen, ex_is_load, ex_mc_issue, mem_rd, mem_regwen,
        output fwa, fwb, stall, mc_busy, mc_wb_req, stall_cnt
    );

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_mc, flush,
        output ex_rd, ex_regwen, ex_is_load, ex_mc_issue, mem_rd, mem_regwen,
        input  fwa, fwb, stall, mc_busy, mc_wb_req, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Registered forwarding-select and hazard-detection unit for the 5-stage core.
// Ports:
//   i_clk    core clock
//   i_rst_n  synchronous active-low reset
//   bus      hazard_fwd_unit_if.slave: ID/EX/MEM pipeline state in; fwa/fwb, stall,
//            mc_busy, mc_wb_req and stall_cnt out
// The EX operand selects are computed for the instruction in ID and registered so they are
// valid when that instruction reaches EX. One outstanding multi-cycle op is tracked with a
// countdown; dependents and further multi-cycle ops stall until its write-back cycle.
module hazard_fwd_unit #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned MC_LAT = 34,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    hazard_fwd_unit_if.slave      bus
);
    localparam int unsigned CntW = $clog2(MC_LAT + 1);

    typedef enum logic {StIdle, StBusy} mc_state_e;

    mc_state_e         r_state;
    mc_state_e         w_state_d;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_d;
    logic [ADDR_W-1:0] r_mc_rd;
    logic [ADDR_W-1:0] w_mc_rd_d;
    logic [1:0]        r_fwa;
    logic [1:0]        r_fwb;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_rs1_ex, w_rs2_ex, w_rs1_mem, w_rs2_mem;
    logic w_busy, w_wb_req, w_lu_stall, w_sb_stall, w_stall;
    logic [1:0] w_fwa_sel, w_fwb_sel;

    // x0 never matches: a zero destination is treated as "no write".
    assign w_rs1_ex  = bus.id_use_rs1 & bus.ex_regwen & (bus.ex_rd != '0)
                       & (bus.ex_rd == bus.id_rs1);
    assign w_rs2_ex  = bus.id_use_rs2 & bus.ex_regwen & (bus.ex_rd != '0)
                       & (bus.ex_rd == bus.id_rs2);
    assign w_rs1_mem = bus.id_use_rs1 & bus.mem_regwen & (bus.mem_rd != '0)
                       & (bus.mem_rd == bus.id_rs1);
    assign w_rs2_mem = bus.id_use_rs2 & bus.mem_regwen & (bus.mem_rd != '0)
                       & (bus.mem_rd == bus.id_rs2);

    assign w_busy   = (r_state == StBusy);
    assign w_wb_req = w_busy & (r_cnt == CntW'(1));

    assign w_lu_stall = bus.ex_is_load & (w_rs1_ex | w_rs2_ex);
    assign w_sb_stall = w_busy & ((bus.id_use_rs1 & (bus.id_rs1 == r_mc_rd) & (r_mc_rd != '0))
                                | (bus.id_use_rs2 & (bus.id_rs2 == r_mc_rd) & (r_mc_rd != '0))
                                | bus.id_is_mc);
    // Flush wins; stall is also masked while reset is asserted.
    assign w_stall = (w_lu_stall | w_sb_stall) & ~bus.flush & i_rst_n;

    // EX match has priority over MEM match; a matching load never reaches here unstalled.
    assign w_fwa_sel = w_rs1_ex ? 2'b10 : (w_rs1_mem ? 2'b01 : 2'b00);
    assign w_fwb_sel = w_rs2_ex ? 2'b10 : (w_rs2_mem ? 2'b01 : 2'b00);

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_mc_rd_d = r_mc_rd;
        unique case (r_state)
            StIdle: begin
                if (bus.ex_mc_issue) begin
                    w_state_d = StBusy;
                    w_cnt_d   = CntW'(MC_LAT);
                    w_mc_rd_d = bus.ex_rd;
                end
            end
            StBusy: begin
                // Issue while busy is impossible by construction and is ignored here.
                if (r_cnt == CntW'(1)) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt - CntW'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_mc_rd     <= '0;
            r_fwa       <= 2'b00;
            r_fwb       <= 2'b00;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_mc_rd <= w_mc_rd_d;
            if (w_stall || bus.flush) begin
                r_fwa <= 2'b00;
                r_fwb <= 2'b00;
            end else begin
                r_fwa <= w_fwa_sel;
                r_fwb <= w_fwb_sel;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.fwa       = r_fwa;
    assign bus.fwb       = r_fwb;
    assign bus.stall     = w_stall;
    assign bus.mc_busy   = w_busy;
    assign bus.mc_wb_req = w_wb_req;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit (MC_LAT=4, CNT_W=4).
// Inputs change 1ns after a rising edge; combinational stall is sampled 1ns later and
// registered outputs are sampled 1ns after the following edge.
module tb_hazard_fwd_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.ADDR_W(5), .CNT_W(4)) bus ();

    hazard_fwd_unit #(
        .ADDR_W(5),
        .MC_LAT(4),
        .CNT_W (4)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // A multi-cycle issue while one is outstanding must never be presented.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(bus.mc_busy && bus.ex_mc_issue))
                else $error("FAIL mc_issue_while_busy");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.id_rs1 = '0;      bus.id_rs2 = '0;
        bus.id_use_rs1 = 0;   bus.id_use_rs2 = 0;
        bus.id_is_mc = 0;     bus.flush = 0;
        bus.ex_rd = '0;       bus.ex_regwen = 0;
        bus.ex_is_load = 0;   bus.ex_mc_issue = 0;
        bus.mem_rd = '0;      bus.mem_regwen = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        // Reset: a load-use pattern is present but stall must stay low.
        bus.ex_is_load = 1; bus.ex_regwen = 1; bus.ex_rd = 5'd9;
        bus.id_rs1 = 5'd9;  bus.id_use_rs1 = 1;
        #1;
        check("rst_stall", 32'(bus.stall), 32'd0);
        step();
        step();
        check("rst_fwa", 32'(bus.fwa), 32'd0);
        check("rst_fwb", 32'(bus.fwb), 32'd0);
        check("rst_busy", 32'(bus.mc_busy), 32'd0);
        check("rst_cnt", 32'(bus.stall_cnt), 32'd0);
        rst_n = 1; idle();
        step();

        // Forward priority: EX beats MEM.
        bus.ex_rd = 5'd5; bus.ex_regwen = 1; bus.mem_rd = 5'd5; bus.mem_regwen = 1;
        bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1;
        #1; check("prio_stall", 32'(bus.stall), 32'd0);
        step();
        check("prio_fwa_ex", 32'(bus.fwa), 32'd2);
        check("prio_fwb", 32'(bus.fwb), 32'd0);
        bus.ex_regwen = 0;
        step();
        check("prio_fwa_mem", 32'(bus.fwa), 32'd1);

        // x0 and unused operand.
        idle();
        bus.ex_rd = 5'd0; bus.ex_regwen = 1; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1;
        step();
        check("x0_fwa", 32'(bus.fwa), 32'd0);
        idle();
        bus.ex_rd = 5'd7; bus.ex_regwen = 1; bus.ex_is_load = 1;
        bus.id_rs2 = 5'd7; bus.id_use_rs2 = 0;
        #1; check("unused_stall", 32'(bus.stall), 32'd0);
        step();
        check("unused_fwb", 32'(bus.fwb), 32'd0);

        // Load-use: one stall cycle, then MEM forward.
        idle();
        bus.ex_rd = 5'd9; bus.ex_regwen = 1; bus.ex_is_load = 1;
        bus.id_rs2 = 5'd9; bus.id_use_rs2 = 1;
        #1; check("lu_stall", 32'(bus.stall), 32'd1);
        step();
        check("lu_fwb_bubble", 32'(bus.fwb), 32'd0);
        check("lu_cnt", 32'(bus.stall_cnt), 32'd1);
        idle();
        bus.mem_rd = 5'd9; bus.mem_regwen = 1;
        bus.id_rs2 = 5'd9; bus.id_use_rs2 = 1;
        #1; check("lu_release", 32'(bus.stall), 32'd0);
        step();
        check("lu_fwb_mem", 32'(bus.fwb), 32'd1);
        check("lu_cnt_hold", 32'(bus.stall_cnt), 32'd1);

        // Multi-cycle op to x12, latency 4.
        idle();
        bus.ex_mc_issue = 1; bus.ex_rd = 5'd12; bus.ex_regwen = 1;
        step();
        idle();
        bus.id_rs1 = 5'd12; bus.id_use_rs1 = 1;
        #1;
        check("mc1_busy", 32'(bus.mc_busy), 32'd1);
        check("mc1_wb", 32'(bus.mc_wb_req), 32'd0);
        check("mc1_dep_stall", 32'(bus.stall), 32'd1);
        step();
        idle();
        bus.id_rs1 = 5'd3; bus.id_use_rs1 = 1;
        #1;
        check("mc2_busy", 32'(bus.mc_busy), 32'd1);
        check("mc2_indep", 32'(bus.stall), 32'd0);
        step();
        idle();
        bus.id_is_mc = 1;
        #1;
        check("mc3_wb", 32'(bus.mc_wb_req), 32'd0);
        check("mc3_struct", 32'(bus.stall), 32'd1);
        step();
        idle();
        bus.id_rs2 = 5'd12; bus.id_use_rs2 = 1;
        #1;
        check("mc4_busy", 32'(bus.mc_busy), 32'd1);
        check("mc4_wb", 32'(bus.mc_wb_req), 32'd1);
        check("mc4_dep_stall", 32'(bus.stall), 32'd1);
        step();
        check("mc5_busy", 32'(bus.mc_busy), 32'd0);
        check("mc5_wb", 32'(bus.mc_wb_req), 32'd0);
        check("mc5_release", 32'(bus.stall), 32'd0);
        check("mc_cnt", 32'(bus.stall_cnt), 32'd4);

        // Flush beats load-use; outstanding mc op survives.
        idle();
        bus.ex_mc_issue = 1; bus.ex_rd = 5'd12; bus.ex_regwen = 1;
        step();
        idle();
        bus.ex_rd = 5'd9; bus.ex_regwen = 1; bus.ex_is_load = 1;
        bus.mem_rd = 5'd4; bus.mem_regwen = 1;
        bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1; bus.id_rs2 = 5'd4; bus.id_use_rs2 = 1;
        bus.flush = 1;
        #1; check("fl_stall", 32'(bus.stall), 32'd0);
        step();
        check("fl_fwa", 32'(bus.fwa), 32'd0);
        check("fl_fwb", 32'(bus.fwb), 32'd0);
        check("fl_busy", 32'(bus.mc_busy), 32'd1);
        idle();
        step();
        // Now cnt==2: reset for one cycle.
        check("pre_rst_busy", 32'(bus.mc_busy), 32'd1);
        rst_n = 0; bus.id_is_mc = 1;
        #1; check("rst_mid_stall", 32'(bus.stall), 32'd0);
        step();
        rst_n = 1; idle();
        #1;
        check("rstm_busy", 32'(bus.mc_busy), 32'd0);
        check("rstm_wb", 32'(bus.mc_wb_req), 32'd0);
        check("rstm_cnt", 32'(bus.stall_cnt), 32'd0);
        check("rstm_fwa", 32'(bus.fwa), 32'd0);
        check("rstm_fwb", 32'(bus.fwb), 32'd0);
        step();
        check("rstm_wb_late", 32'(bus.mc_wb_req), 32'd0);
        check("rstm_busy_late", 32'(bus.mc_busy), 32'd0);

        // Saturation: 2^4+3 stalled cycles.
        bus.ex_rd = 5'd9; bus.ex_regwen = 1; bus.ex_is_load = 1;
        bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1;
        for (int i = 0; i < 14; i++) step();
        check("sat_14", 32'(bus.stall_cnt), 32'd14);
        for (int i = 0; i < 5; i++) step();
        check("sat_cnt", 32'(bus.stall_cnt), 32'd15);
        check("sat_stall", 32'(bus.stall), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Registered forwarding-select and hazard-detection unit for the 5-stage RISC-V core; next generation of the combinational forwarding unit.
- Evaluates operands of the instruction in ID and registers the EX-stage operand-mux selects for the following cycle.
- Generates load-use stalls.
- Tracks one outstanding long-latency operation (mul/div) with a countdown scoreboard, stalling dependent and structurally conflicting instructions.

Parameters:
- ADDR_W, 5, register-address width (4 for RV32E).
- MC_LAT, 34, multi-cycle unit latency in cycles from issue to write-back request; must be >= 2.
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- id_rs1, id_rs2  in  ADDR_W  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2
- id_is_mc  in  1  ID instruction is a multi-cycle op
- flush  in  1  ID instruction is being killed (taken branch or jump)
- ex_rd  in  ADDR_W  destination register of the instruction in EX
- ex_regwen  in  1  EX instruction writes the register file
- ex_is_load  in  1  EX instruction is a load
- ex_mc_issue  in  1  EX instruction is issuing to the multi-cycle unit this cycle
- mem_rd  in  ADDR_W  destination register of the instruction in MEM
- mem_regwen  in  1  MEM instruction writes the register file
- fwa, fwb  out  2  registered EX operand selects: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX (combinational)
- mc_busy  out  1  multi-cycle operation outstanding
- mc_wb_req  out  1  multi-cycle result to be written this cycle
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (synchronous, rst_n=0 at posedge): fwa=fwb=00, mc_busy=0, internal counter=0, mc_rd=0, stall_cnt=0. Combinational stall=0 while rst_n=0. Reset mid-operation abandons the tracked multi-cycle op.
- Match definitions:
  - rsX_ex = id_use_rsX & ex_regwen & (ex_rd!=0) & (ex_rd==id_rsX)
  - rsX_mem = id_use_rsX & mem_regwen & (mem_rd!=0) & (mem_rd==id_rsX)
  - Register x0 never matches anything.
- Load-use stall: ex_is_load & (rs1_ex | rs2_ex).
- Scoreboard stall: mc_busy & ((id_use_rs1 & id_rs1==mc_rd & mc_rd!=0) | (id_use_rs2 & id_rs2==mc_rd & mc_rd!=0) | id_is_mc).
- stall = (load-use | scoreboard stall) & ~flush. A flush always wins.
- Forward selects, registered at each posedge:
  - If stall or flush, fwa=fwb=00 (bubble enters EX).
  - Otherwise, per operand: 10 if rsX_ex, else 01 if rsX_mem, else 00. EX match has priority over MEM match.
  - A load in EX that matches never yields 10; it stalls instead. On the following cycle the load sits in MEM, its match gives 01, and the select is valid because the load reaches WB when the consumer reaches EX.
- Multi-cycle FSM, states IDLE and BUSY:
  - IDLE -> BUSY on ex_mc_issue & (ex_rd!=0 or not; the op is always tracked). Captures mc_rd=ex_rd and sets cnt=MC_LAT.
  - In BUSY, cnt decrements by 1 per cycle.
  - mc_wb_req=1 exactly in the cycle cnt==1.
  - BUSY -> IDLE on the next edge, with mc_busy=0 and cnt=0.
  - mc_busy is high from the cycle after issue through the cycle mc_wb_req is high, i.e. MC_LAT cycles.
  - The register file is write-first, so a dependent released the cycle after mc_wb_req reads the correct value.
- ex_mc_issue while BUSY cannot occur, since ID stalls multi-cycle ops while busy. If it does, it is ignored and flagged by a bench assertion.
- flush does not cancel an outstanding multi-cycle operation.
- stall_cnt increments on every cycle with stall=1 and saturates at all-ones.

Test Plan:
- Forward priority: ex_rd=5, mem_rd=5, both regwen, id_rs1=5, use_rs1=1, no load -> next cycle fwa=10, fwb=00, stall=0. With ex_regwen=0 -> fwa=01.
- x0 and unused operands: ex_rd=0 with regwen, id_rs1=0 -> fwa=00. id_rs2=7 matching ex_rd=7 with id_use_rs2=0 -> fwb=00, no stall.
- Load-use: ex_is_load, ex_rd=9, id_rs2=9 -> stall=1 for exactly 1 cycle, fwb=00 registered. Next cycle (mem_rd=9) -> stall=0, fwb=01. stall_cnt=1.
- Multi-cycle: ex_mc_issue with ex_rd=12, MC_LAT=4 -> mc_busy high for 4 cycles, mc_wb_req on the 4th. ID reading x12 stalls through the mc_wb_req cycle and is released the next cycle. An independent ID instruction does not stall. A second mc op in ID stalls.
- Flush precedence: load-use condition together with flush=1 -> stall=0, fwa=fwb=00. An outstanding mc op is unaffected.
- Reset mid-BUSY: rst_n=0 for 1 cycle at cnt=2 -> mc_busy=0, no mc_wb_req, stall_cnt=0, fwa=fwb=00. Saturation: hold a stall for 2^CNT_W+3 cycles with CNT_W=4 -> stall_cnt=15.
